// File: rtl/wt_mul_arbiter.sv
// Purpose : wt_s is a 16x16 Wallace-tree multiplier (carry-save 3:2 reduction, one final add).
//           wt_mul_arbiter shares one wt_s between two requesters, granting them round-robin.
// Latency : wt_s is combinational. The arbiter raises rsp_valid MUL_CYCLES+1 edges after the
//           request handshake edge.
// Backpr. : The owner may hold rsp_ready low indefinitely. Until it accepts, no new request is
//           accepted (req_ready=0).
//
// wt_s ports : a, b (16-bit operands), alufn (0 = signed, 1 = unsigned), c (32-bit product).
// wt_mul_arbiter ports :
//   clk, rst_n                  clock and asynchronous active-low reset
//   req_valid/req_ready [1:0]   request handshake; bit i = requester i
//   req_a*/req_b*/req_alufn*    per-requester operands and mode
//   rsp_valid/rsp_ready [1:0]   result handshake to the owning requester
//   rsp_data [31:0]             captured product
//   busy                        high while an operation is in MUL or RESP

module wt_s (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        alufn,
    output logic [31:0] c
);
    // Both operands are extended to 32 bits: sign-extended when alufn=0, zero-extended when
    // alufn=1. The low 32 bits of the 32x32 product are then exact for either interpretation.
    logic [31:0] a_ext;
    logic [31:0] b_ext;
    logic [31:0] row [64];
    logic [31:0] nxt [64];
    logic [5:0]  n_rows;
    logic [5:0]  m_rows;
    logic [5:0]  jj;

    always_comb begin
        a_ext  = alufn ? {16'h0000, a} : {{16{a[15]}}, a};
        b_ext  = alufn ? {16'h0000, b} : {{16{b[15]}}, b};
        n_rows = 6'd32;
        m_rows = 6'd0;
        jj     = 6'd0;
        for (int i = 0; i < 64; i++) begin
            row[i[5:0]] = 32'h0;
            nxt[i[5:0]] = 32'h0;
        end
        for (int i = 0; i < 32; i++) begin
            row[i[5:0]] = b_ext[i[4:0]] ? (a_ext << i) : 32'h0;
        end
        // Eight levels of 3:2 compression take the rows 32->22->15->10->7->5->4->3->2.
        // Rows left over after the groups of three pass straight through to the next level.
        for (int lvl = 0; lvl < 8; lvl++) begin
            for (int i = 0; i < 64; i++) begin
                nxt[i[5:0]] = 32'h0;
            end
            m_rows = 6'd0;
            for (int j = 0; j < 32; j += 3) begin
                jj = j[5:0];
                if (jj + 6'd2 < n_rows) begin
                    nxt[m_rows]         = row[jj] ^ row[jj + 6'd1] ^ row[jj + 6'd2];
                    nxt[m_rows + 6'd1]  = ((row[jj] & row[jj + 6'd1]) |
                                           (row[jj] & row[jj + 6'd2]) |
                                           (row[jj + 6'd1] & row[jj + 6'd2])) << 1;
                    m_rows = m_rows + 6'd2;
                end else begin
                    if (jj < n_rows) begin
                        nxt[m_rows] = row[jj];
                        m_rows      = m_rows + 6'd1;
                    end
                    if (jj + 6'd1 < n_rows) begin
                        nxt[m_rows] = row[jj + 6'd1];
                        m_rows      = m_rows + 6'd1;
                    end
                end
            end
            row    = nxt;
            n_rows = m_rows;
        end
        c = row[0] + row[1];
    end
endmodule

module wt_mul_arbiter #(
    parameter int unsigned MUL_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [15:0] req_a0,
    input  logic [15:0] req_b0,
    input  logic        req_alufn0,
    input  logic [15:0] req_a1,
    input  logic [15:0] req_b1,
    input  logic        req_alufn1,
    output logic [1:0]  rsp_valid,
    input  logic [1:0]  rsp_ready,
    output logic [31:0] rsp_data,
    output logic        busy
);
    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_RESP} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(MUL_CYCLES - 1);

    state_t      state_q, state_d;
    logic        ptr_q, ptr_d;       // 1 = requester 1 wins a tie
    logic        owner_q, owner_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic        alufn_q, alufn_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic [1:0]  rsp_valid_q, rsp_valid_d;
    logic        busy_q, busy_d;
    logic [1:0]  gnt;
    logic [31:0] mul_c;

    // Operands stay registered for the whole MUL window, so the tree has MUL_CYCLES to settle.
    wt_s u_wt_s (
        .a     (a_q),
        .b     (b_q),
        .alufn (alufn_q),
        .c     (mul_c)
    );

    always_comb begin
        gnt = 2'b00;
        unique case (req_valid)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = ptr_q ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

    // Masked by rst_n so that no request is accepted while reset is held.
    assign req_ready = (state_q == ST_IDLE && rst_n) ? gnt : 2'b00;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        alufn_d     = alufn_q;
        rsp_data_d  = rsp_data_q;
        rsp_valid_d = rsp_valid_q;
        busy_d      = busy_q;
        unique case (state_q)
            ST_IDLE: begin
                if ((req_valid & req_ready) != 2'b00) begin
                    owner_d = req_ready[1];
                    a_d     = req_ready[1] ? req_a1     : req_a0;
                    b_d     = req_ready[1] ? req_b1     : req_b0;
                    alufn_d = req_ready[1] ? req_alufn1 : req_alufn0;
                    ptr_d   = ~req_ready[1];
                    cnt_d   = CNT_LOAD;
                    state_d = ST_MUL;
                    busy_d  = 1'b1;
                end
            end
            ST_MUL: begin
                if (cnt_q == 4'd0) begin
                    rsp_data_d  = mul_c;
                    rsp_valid_d = owner_q ? 2'b10 : 2'b01;
                    state_d     = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                // Only the owner's bit is set in rsp_valid_q, so the non-owner's rsp_ready is ignored.
                if ((rsp_valid_q & rsp_ready) != 2'b00) begin
                    rsp_valid_d = 2'b00;
                    busy_d      = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= 1'b0;
            owner_q     <= 1'b0;
            cnt_q       <= 4'd0;
            a_q         <= 16'h0;
            b_q         <= 16'h0;
            alufn_q     <= 1'b0;
            rsp_data_q  <= 32'h0;
            rsp_valid_q <= 2'b00;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            alufn_q     <= alufn_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_wt_mul_arbiter.sv
// Purpose : testbench for wt_mul_arbiter, with a default build and a MUL_CYCLES=1 build.
// Latency : a transaction-level model predicts every output on each falling edge.
// Backpr. : random rsp_ready stalls, plus a directed 10-cycle owner stall.
module tb_wt_mul_arbiter;
    localparam int MC = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
    logic [15:0] req_a0, req_b0, req_a1, req_b1;
    logic        req_alufn0, req_alufn1;
    logic [31:0] rsp_data;
    logic        busy;

    logic [1:0]  s_req_valid, s_req_ready, s_rsp_valid, s_rsp_ready;
    logic [15:0] s_req_a0, s_req_b0;
    logic [31:0] s_rsp_data;
    logic        s_busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    wt_mul_arbiter #(.MUL_CYCLES(MC)) u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_a0(req_a0), .req_b0(req_b0), .req_alufn0(req_alufn0),
        .req_a1(req_a1), .req_b1(req_b1), .req_alufn1(req_alufn1),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .busy(busy)
    );

    wt_mul_arbiter #(.MUL_CYCLES(1)) u_one (
        .clk(clk), .rst_n(rst_n), .req_valid(s_req_valid), .req_ready(s_req_ready),
        .req_a0(s_req_a0), .req_b0(s_req_b0), .req_alufn0(1'b0),
        .req_a1(16'h0), .req_b1(16'h0), .req_alufn1(1'b0),
        .rsp_valid(s_rsp_valid), .rsp_ready(s_rsp_ready), .rsp_data(s_rsp_data), .busy(s_busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_state = 0;   // 0 idle, 1 multiplying, 2 result offered
    int          m_wait  = 0;
    int          m_done  = 0;
    logic        m_owner = 1'b0;
    logic        m_ptr   = 1'b0;
    logic [31:0] m_prod  = 32'h0;
    logic [31:0] m_data  = 32'h0;

    function automatic logic [1:0] m_grant(input logic [1:0] v, input logic p);
        if (v == 2'b11) return p ? 2'b10 : 2'b01;
        return v;
    endfunction

    function automatic logic [31:0] m_mul(input logic [15:0] a, input logic [15:0] b, input logic f);
        longint sa, sb;
        if (f) begin
            sa = longint'(a);
            sb = longint'(b);
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end
        return 32'(sa * sb);
    endfunction

    always @(negedge clk) begin
        logic [1:0] e_rdy, e_rv, hs;
        if (!rst_n) begin
            check("rst_req_ready", 32'(req_ready), 32'h0);
            check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
            check("rst_rsp_data", rsp_data, 32'h0);
            check("rst_busy", 32'(busy), 32'h0);
            m_state = 0;
            m_ptr   = 1'b0;
            m_data  = 32'h0;
        end else begin
            e_rdy = (m_state == 0) ? m_grant(req_valid, m_ptr) : 2'b00;
            e_rv  = (m_state == 2) ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
            check("req_ready", 32'(req_ready), 32'(e_rdy));
            check("rsp_valid", 32'(rsp_valid), 32'(e_rv));
            check("rsp_data", rsp_data, m_data);
            check("busy", 32'(busy), 32'(m_state != 0));
            check("req_ready_onehot", 32'($countones(req_ready) <= 1), 32'h1);
            hs = e_rdy & req_valid;
            case (m_state)
                0: if (hs != 2'b00) begin
                    m_owner = hs[1];
                    m_prod  = hs[1] ? m_mul(req_a1, req_b1, req_alufn1)
                                    : m_mul(req_a0, req_b0, req_alufn0);
                    m_ptr   = ~hs[1];
                    m_wait  = MC;
                    m_state = 1;
                end
                1: begin
                    m_wait--;
                    if (m_wait == 0) begin
                        m_data  = m_prod;
                        m_state = 2;
                    end
                end
                2: if (rsp_ready[m_owner]) begin
                    m_state = 0;
                    m_done++;
                end
                default: m_state = 0;
            endcase
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 2'b00;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_rsp(input logic [1:0] mask, input string name);
        int g = 0;
        do begin
            @(negedge clk);
            g++;
        end while ((rsp_valid & mask) == 2'b00 && g < 60);
        check(name, 32'((rsp_valid & mask) != 2'b00), 32'h1);
    endtask

    // Called just after a rising edge. Returns edges from the request handshake to rsp_valid.
    task automatic req_once(input int i, input logic [15:0] a, input logic [15:0] b, input logic f,
                            output int edges, output logic [31:0] data);
        int g = 0;
        if (i == 0) begin
            req_a0 = a; req_b0 = b; req_alufn0 = f;
        end else begin
            req_a1 = a; req_b1 = b; req_alufn1 = f;
        end
        req_valid[i[0]] = 1'b1;
        rsp_ready[i[0]] = 1'b1;
        do begin
            @(negedge clk);
            g++;
        end while (!req_ready[i[0]] && g < 40);
        check("grant_seen", 32'(req_ready[i[0]]), 32'h1);
        @(posedge clk);
        edges = 1;
        #1 req_valid[i[0]] = 1'b0;
        while (!rsp_valid[i[0]] && edges < 40) begin
            @(posedge clk); #1;
            edges++;
        end
        data = rsp_data;
        @(posedge clk); #1;
    endtask

    function automatic logic [15:0] rnd16();
        case ($urandom_range(0, 5))
            0:       return 16'h8000;
            1:       return 16'hFFFF;
            2:       return 16'h7FFF;
            3:       return 16'h0000;
            default: return 16'($urandom);
        endcase
    endfunction

    typedef struct packed {
        logic        who;
        logic [15:0] a;
        logic [15:0] b;
        logic        f;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs [7];
    logic [1:0]  c_own [3];
    logic [31:0] c_dat [3];
    logic [1:0]  hs_seen;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          e;
        logic [31:0] d;
        int          g;

        rst_n = 1'b1;
        req_valid = 2'b00; rsp_ready = 2'b00;
        req_a0 = '0; req_b0 = '0; req_alufn0 = 1'b0;
        req_a1 = '0; req_b1 = '0; req_alufn1 = 1'b0;
        s_req_valid = 2'b00; s_rsp_ready = 2'b00; s_req_a0 = '0; s_req_b0 = '0;
        #1 rst_n = 1'b0;
        #1;
        check("reset_req_ready", 32'(req_ready), 32'h0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        check("reset_rsp_data", rsp_data, 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Directed single requests, signed, unsigned and boundary operands.
        vecs[0] = '{1'b0, 16'd36,   16'd36,   1'b0, 32'h0000_0510};
        vecs[1] = '{1'b1, 16'hFFDC, 16'd36,   1'b0, 32'hFFFF_FAF0};
        vecs[2] = '{1'b1, 16'hFFDC, 16'hFFDC, 1'b0, 32'h0000_0510};
        vecs[3] = '{1'b1, 16'h0000, 16'd36,   1'b0, 32'h0000_0000};
        vecs[4] = '{1'b0, 16'h8000, 16'h8000, 1'b0, 32'h4000_0000};
        vecs[5] = '{1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 32'hFFFE_0001};
        vecs[6] = '{1'b1, 16'h8000, 16'h7FFF, 1'b0, 32'hC000_8000};
        for (int k = 0; k < 7; k++) begin
            req_once(int'(vecs[k].who), vecs[k].a, vecs[k].b, vecs[k].f, e, d);
            check("single_latency", 32'(e), 32'(MC + 1));
            check("single_data", d, vecs[k].exp);
            if (k == 0) begin
                @(negedge clk);
                check("single_busy_after", 32'(busy), 32'h0);
                @(posedge clk); #1;
            end
        end

        // Contention from reset: grants alternate 0,1,0.
        do_reset();
        req_a0 = 16'd2; req_b0 = 16'd3; req_alufn0 = 1'b0;
        req_a1 = 16'd4; req_b1 = 16'd5; req_alufn1 = 1'b0;
        req_valid = 2'b11; rsp_ready = 2'b11;
        c_own[0] = 2'b01; c_own[1] = 2'b10; c_own[2] = 2'b01;
        c_dat[0] = 32'd6; c_dat[1] = 32'd20; c_dat[2] = 32'd6;
        for (int k = 0; k < 3; k++) begin
            wait_rsp(2'b11, "contend_rsp_seen");
            check("contend_owner", 32'(rsp_valid), 32'(c_own[k]));
            check("contend_data", rsp_data, c_dat[k]);
            @(posedge clk); #1;
        end
        req_valid = 2'b00;

        // Backpressure: requester 1 is stalled while requester 0 waits.
        req_a1 = 16'd7; req_b1 = 16'hFFF7; req_alufn1 = 1'b0;
        req_a0 = 16'd100; req_b0 = 16'd200; req_alufn0 = 1'b0;
        rsp_ready = 2'b00; req_valid = 2'b10;
        wait_rsp(2'b10, "bp_rsp_seen");
        @(posedge clk); #1;
        req_valid = 2'b01; rsp_ready = 2'b01;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("bp_hold_data", rsp_data, 32'hFFFF_FFC1);
            check("bp_hold_ready", 32'(req_ready), 32'h0);
            check("bp_hold_valid", 32'(rsp_valid), 32'h2);
        end
        @(posedge clk); #1;
        rsp_ready = 2'b11;
        wait_rsp(2'b01, "bp_second_seen");
        check("bp_second_data", rsp_data, 32'd20000);
        @(posedge clk); #1;
        req_valid = 2'b00;

        // Asynchronous reset while multiplying.
        req_a1 = 16'd5; req_b1 = 16'd5; req_valid = 2'b10; rsp_ready = 2'b00;
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (!req_ready[1] && g < 20);
        check("ar_grant", 32'(req_ready), 32'h2);
        @(posedge clk); #2;
        check("ar_busy_pre", 32'(busy), 32'h1);
        req_valid = 2'b00;
        rst_n = 1'b0;
        #1;
        check("ar_req_ready", 32'(req_ready), 32'h0);
        check("ar_rsp_valid", 32'(rsp_valid), 32'h0);
        check("ar_rsp_data", rsp_data, 32'h0);
        check("ar_busy", 32'(busy), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        req_a0 = 16'd9; req_b0 = 16'd9; req_alufn0 = 1'b0;
        req_a1 = 16'd3; req_b1 = 16'd3; req_alufn1 = 1'b0;
        req_valid = 2'b11; rsp_ready = 2'b11;
        @(negedge clk);
        check("ar_first_grant", 32'(req_ready), 32'h1);
        wait_rsp(2'b01, "ar_rsp_seen");
        check("ar_data", rsp_data, 32'd81);
        @(posedge clk); #1;
        req_valid = 2'b00;

        // MUL_CYCLES=1 build: result two edges after the handshake.
        s_req_a0 = 16'hFFFF; s_req_b0 = 16'hFFFF; s_req_valid = 2'b01; s_rsp_ready = 2'b01;
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (!s_req_ready[0] && g < 20);
        check("one_grant", 32'(s_req_ready), 32'h1);
        @(posedge clk);
        e = 1;
        #1 s_req_valid = 2'b00;
        while (!s_rsp_valid[0] && e < 20) begin
            @(posedge clk); #1;
            e++;
        end
        check("one_latency", 32'(e), 32'd2);
        check("one_data", s_rsp_data, 32'h0000_0001);
        @(posedge clk); #1;
        check("one_busy_after", 32'(s_busy), 32'h0);

        // Random traffic: requests, withdrawals and result stalls.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            hs_seen = req_valid & req_ready;
            @(posedge clk); #1;
            for (int r = 0; r < 2; r++) begin
                if (hs_seen[r[0]]) begin
                    req_valid[r[0]] = 1'b0;
                end else if (req_valid[r[0]]) begin
                    if ($urandom_range(0, 19) == 0) req_valid[r[0]] = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    if (r == 0) begin
                        req_a0 = rnd16(); req_b0 = rnd16(); req_alufn0 = 1'($urandom);
                    end else begin
                        req_a1 = rnd16(); req_b1 = rnd16(); req_alufn1 = 1'($urandom);
                    end
                    req_valid[r[0]] = 1'b1;
                end
                rsp_ready[r[0]] = ($urandom_range(0, 3) != 0);
            end
        end
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        repeat (10) @(posedge clk);
        check("rand_progress", 32'(m_done > 100), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/wt_mul_arbiter.md
Name: wt_mul_arbiter

Overview:
- Shares one combinational wt_s Wallace-tree multiplier (16x16 in, 32-bit out, alufn mode select) between two requesters.
- Arbitrates requests round-robin and registers the operands into wt_s.
- Holds them for a multicycle settle window, then captures the product and returns it to the owning requester over a valid/ready handshake.
- Sits between CPU-side ALU sequencing logic and the multiplier; the multicycle window absorbs wt_s combinational delay on iCE40.

Parameters:
- MUL_CYCLES, 2, cycles operands are held stable before product capture; legal 1..15.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  2  per-requester request valid; bit i = requester i
- req_ready  output  2  per-requester request accept; one-hot or zero
- req_a0  input  16  requester 0 operand A
- req_b0  input  16  requester 0 operand B
- req_alufn0  input  1  requester 0 mode, forwarded to wt_s alufn
- req_a1  input  16  requester 1 operand A
- req_b1  input  16  requester 1 operand B
- req_alufn1  input  1  requester 1 mode
- rsp_valid  output  2  per-requester result valid; one-hot or zero
- rsp_ready  input  2  per-requester result accept
- rsp_data  output  32  captured product; valid for the requester flagged in rsp_valid
- busy  output  1  high whenever state is not IDLE

Behaviour:
- Reset (async, rst_n low): state IDLE.
  - req_ready=0, rsp_valid=0, rsp_data=0, busy=0.
  - Operand registers=0, alufn register=0.
  - Round-robin pointer = requester 0 has priority.
- States: IDLE, MUL, RESP.
- IDLE:
  - req_ready is combinational: asserted for the granted requester only, while state==IDLE.
  - Grant rule: if exactly one req_valid bit is high, grant it. If both are high, grant the requester the pointer favours.
  - On handshake (req_valid[i] & req_ready[i]) at a clock edge: latch a/b/alufn of requester i and record owner=i.
  - At that edge also: flip the pointer to favour the other requester, load counter=MUL_CYCLES-1, and go to MUL.
- MUL:
  - Operand registers drive wt_s A/B/alufn unchanged; req_ready=0.
  - Counter decrements each cycle.
  - In the cycle the counter reads 0: capture wt_s C into rsp_data and go to RESP.
  - Latency: request handshake edge to rsp_valid high = MUL_CYCLES+1 edges (3 at default).
- RESP:
  - rsp_valid[owner]=1; rsp_data stable until handshake.
  - On rsp_valid[owner] & rsp_ready[owner]: go to IDLE, drop rsp_valid.
  - A new grant is possible on the next cycle, not the same one; throughput is one product per MUL_CYCLES+2 cycles minimum.
  - rsp_ready of the non-owner is ignored. rsp_ready high before rsp_valid has no effect.
- Backpressure: the owner may stall in RESP indefinitely. Pending requests wait with req_ready=0 and no inputs are sampled.
- Requesters must hold req_valid and operands until handshake. Deassertion without handshake simply withdraws the request, with no side effect.
- Arithmetic:
  - alufn=0: rsp_data = signed two's-complement 16x16 product, full 32 bits, no truncation.
  - alufn=1: rsp_data = wt_s output unmodified.
- Fairness: under continuous requests from both, grants strictly alternate.
  - The pointer updates only on a granted handshake, never when idle.
- Reset mid-operation (any state): immediately returns to reset values. The in-flight result is discarded and no rsp_valid pulse is produced.
- busy=1 in MUL and RESP.

Test Plan:
- Single request, alufn=0: requester 0, a=36, b=36 -> rsp_valid=01 exactly 3 edges after handshake, rsp_data=0x00000510 (1296); busy low after rsp handshake.
- Signed operands: requester 1, a=-36 (0xFFDC), b=36 -> rsp_valid=10, rsp_data=0xFFFFFAF0 (-1296); then a=-36, b=-36 -> 0x00000510; a=0, b=36 -> 0.
- Contention: both valid from reset with operands (2,3) and (4,5), held high -> requester 0 is granted first (rsp 6), then requester 1 (rsp 20), then requester 0 again; req_ready never two-hot.
- Backpressure: owner rsp_ready held low 10 cycles -> rsp_data held at the product; other requester's req_ready stays 0; completes correctly after rsp_ready rises.
- Async reset in MUL: pull rst_n low mid-count, no clock edge -> all outputs at reset values at once; after release no stale rsp_valid, and the next request is granted to requester 0.
- MUL_CYCLES=1 build: a=-1 (0xFFFF), b=-1 -> rsp_data=0x00000001 exactly 2 edges after handshake.
